// File: rtl/store_merge.sv
// Store merge unit: aligns SB/SH/SW data onto 32-bit word lanes and drives one memory write.
// Build option: define STORE_RMW_EN to read-modify-write SB/SH as full-word writes.
//
// state | meaning
// IDLE  | ready for a request; done pulses here after a completed write
// READ  | RMW only: mem_re held until mem_rvalid, read word merged with new lanes
// WRITE | mem_we held with stable addr/data/be until mem_ack
// ERR   | one-cycle err pulse for a dropped misaligned/illegal request
module store_merge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              done,
  output logic              err
);

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                done_q, done_d;

  logic                legal;
  logic                needs_read;
  logic [3:0]          be_new;
  logic [31:0]         wd_new;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Lane placement of the incoming request; only meaningful in IDLE.
  always_comb begin
    legal  = 1'b0;
    be_new = 4'b0000;
    wd_new = '0;
    case (opcode)
      OP_SB: begin
        legal  = 1'b1;
        be_new = 4'b0001 << addr[1:0];
        wd_new = {4{wdata[7:0]}};
      end
      OP_SH: begin
        legal  = ~addr[0];
        be_new = addr[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{wdata[15:0]}};
      end
      OP_SW: begin
        legal  = (addr[1:0] == 2'b00);
        be_new = 4'b1111;
        wd_new = wdata;
      end
      default: ;
    endcase
    wd_new = wd_new & lane_mask(be_new);
  end

`ifdef STORE_RMW_EN
  assign needs_read = (opcode != OP_SW);
`else
  assign needs_read = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal)          state_d = ERR;
          else if (needs_read) state_d = READ;
          else                 state_d = WRITE;
        end
      end
      READ:    if (mem_rvalid) state_d = WRITE;
      WRITE:   if (mem_ack)    state_d = IDLE;
      ERR:                     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = (state_q == WRITE) && mem_ack;
    if (state_q == IDLE && req_valid && legal) begin
      addr_d  = {addr[ADDR_W-1:2], 2'b00};
      wdata_d = wd_new;
      be_d    = be_new;
    end
    // Merged word is always written whole, so enables widen to the full word.
    if (state_q == READ && mem_rvalid) begin
      wdata_d = (mem_rdata & ~lane_mask(be_q)) | wdata_q;
      be_d    = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_we    = (state_q == WRITE);
`ifdef STORE_RMW_EN
    mem_re    = (state_q == READ);
`else
    mem_re    = 1'b0;
`endif
    err       = (state_q == ERR);
    done      = done_q;
    mem_addr  = (state_q == READ || state_q == WRITE) ? addr_q : '0;
    mem_wdata = (state_q == WRITE) ? wdata_q : '0;
    mem_be    = (state_q == WRITE) ? be_q : 4'b0000;
  end

endmodule
